// File: rtl/fetch_redirect_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_redirect_pkg;

  localparam int PC_W        = 16;
  localparam int INSTR_BYTES = 2;

  localparam logic [PC_W-1:0] RESET_PC_DFLT = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } fr_state_e;

  // Instructions are 2-byte aligned; an odd fetch address is unusable.
  function automatic logic pc_misaligned(input logic [PC_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Redirect/fetch bus between the execute-stage branch unit, the PC sequencer and IF/ID.
interface fetch_redirect_if;
  import fetch_redirect_pkg::*;

  logic            stall;
  logic            halt;
  logic            redir_valid;
  logic [PC_W-1:0] redir_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus_two;
  logic            fetch_valid;
  logic            squash;
  logic            halted;
  logic            err;

  modport master (
    output stall, halt, redir_valid, redir_target,
    input  pc, pc_plus_two, fetch_valid, squash, halted, err
  );

  modport slave (
    input  stall, halt, redir_valid, redir_target,
    output pc, pc_plus_two, fetch_valid, squash, halted, err
  );

endinterface

// File: rtl/fetch_redirect_cla_16b.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level across groups.
module cla_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_in_i,
  output logic [15:0] sum_o,
  output logic        c_out_o
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [4:0]  cg_s;
  logic [15:0] c_s;

  assign g_s = a_i & b_i;
  assign p_s = a_i ^ b_i;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg_s[k] = g_s[4*k+3]
                   | (p_s[4*k+3] & g_s[4*k+2])
                   | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                   | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
    assign gp_s[k] = &p_s[4*k +: 4];

    assign c_s[4*k]   = cg_s[k];
    assign c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & cg_s[k]);
    assign c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                      | (p_s[4*k+1] & p_s[4*k] & cg_s[k]);
    assign c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                      | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                      | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & cg_s[k]);
  end

  assign cg_s[0] = c_in_i;
  assign cg_s[1] = gg_s[0] | (gp_s[0] & c_in_i);
  assign cg_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & c_in_i);
  assign cg_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                 | (gp_s[2] & gp_s[1] & gp_s[0] & c_in_i);
  assign cg_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                 | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                 | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & c_in_i);

  assign sum_o   = p_s ^ c_s;
  assign c_out_o = cg_s[4];

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC sequencer: advances the PC by one instruction, loads taken-branch targets and
// emits a fixed run of squash bubbles so wrong-path slots in IF/ID and ID/EX are killed.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DFLT,
  parameter int unsigned     SQUASH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_redirect_if.slave bus
);

  localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CYCLES - 1);

  fr_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      sq_cnt_q, sq_cnt_d;
  logic            err_q, err_d;

  logic [PC_W-1:0] pc_inc_s;
  logic            inc_carry_s;
  logic            redir_bad_s;

  cla_16b u_inc (
    .a_i     (pc_q),
    .b_i     (PC_W'(INSTR_BYTES)),
    .c_in_i  (1'b0),
    .sum_o   (pc_inc_s),
    .c_out_o (inc_carry_s)
  );

  assign redir_bad_s = pc_misaligned(bus.redir_target);

  // State, PC, squash counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      sq_cnt_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sq_cnt_q <= sq_cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; a redirect outranks halt and stall because both belong to the wrong path.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sq_cnt_d = sq_cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_RUN, ST_SQUASH: begin
        if (bus.redir_valid) begin
          pc_d = bus.redir_target;
          if (redir_bad_s) begin
            err_d    = 1'b1;
            sq_cnt_d = 3'd0;
            state_d  = ST_HALT;
          end else begin
            sq_cnt_d = SQ_RELOAD;
            state_d  = ST_SQUASH;
          end
        end else if (state_q == ST_SQUASH) begin
          if (sq_cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            sq_cnt_d = sq_cnt_q - 3'd1;
          end
        end else if (bus.halt) begin
          state_d = ST_HALT;
        end else if (!bus.stall) begin
          pc_d  = pc_inc_s;
          err_d = err_q | inc_carry_s;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d  = ST_RUN;
        sq_cnt_d = 3'd0;
      end
    endcase
  end

  // fetch_valid is gated by rst_n so nothing is captured while reset is held.
  assign bus.pc          = pc_q;
  assign bus.pc_plus_two = pc_inc_s;
  assign bus.fetch_valid = rst_n & (state_q == ST_RUN) & ~bus.stall;
  assign bus.squash      = (state_q == ST_SQUASH);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed and randomized check of fetch_redirect against a bubble-count reference model.
module tb_fetch_redirect;
  import fetch_redirect_pkg::*;

  localparam int SQ = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_redirect_if bus();

  fetch_redirect #(.RESET_PC(16'h0000), .SQUASH_CYCLES(SQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: PC, number of bubbles still owed, parked flag, sticky error.
  logic [15:0] m_pc;
  int          m_bubbles;
  bit          m_halted;
  bit          m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_bubbles = 0;
    m_halted  = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [15:0] pp2;
    pp2 = m_pc + 16'd2;
    check_eq("pc",          {16'h0, bus.pc},          {16'h0, m_pc});
    check_eq("pc_plus_two", {16'h0, bus.pc_plus_two}, {16'h0, pp2});
    check_eq("fetch_valid", {31'h0, bus.fetch_valid},
             {31'h0, (!m_halted && m_bubbles == 0 && !bus.stall)});
    check_eq("squash",      {31'h0, bus.squash},      {31'h0, (m_bubbles > 0)});
    check_eq("halted",      {31'h0, bus.halted},      {31'h0, m_halted});
    check_eq("err",         {31'h0, bus.err},         {31'h0, m_err});
  endtask

  task automatic model_step();
    logic [16:0] sum;
    if (m_halted) begin
      m_halted = 1'b1;
    end else if (bus.redir_valid) begin
      m_pc = bus.redir_target;
      if (bus.redir_target % 2 == 1) begin
        m_err     = 1'b1;
        m_halted  = 1'b1;
        m_bubbles = 0;
      end else begin
        m_bubbles = SQ;
      end
    end else if (m_bubbles > 0) begin
      m_bubbles--;
    end else if (bus.halt) begin
      m_halted = 1'b1;
    end else if (!bus.stall) begin
      sum  = {1'b0, m_pc} + 17'd2;
      m_pc = sum[15:0];
      if (sum[16]) m_err = 1'b1;
    end
  endtask

  task automatic cyc(input logic s, input logic h, input logic rv, input logic [15:0] t);
    bus.stall        = s;
    bus.halt         = h;
    bus.redir_valid  = rv;
    bus.redir_target = t;
    #1;
    compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.stall        = 1'b0;
    bus.halt         = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_target = 16'h0000;
    #1;
    check_eq("rst_pc",     {16'h0, bus.pc},     32'h0000_0000);
    check_eq("rst_fv",     {31'h0, bus.fetch_valid}, 32'd0);
    check_eq("rst_squash", {31'h0, bus.squash}, 32'd0);
    check_eq("rst_halted", {31'h0, bus.halted}, 32'd0);
    check_eq("rst_err",    {31'h0, bus.err},    32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_pc_hold", {16'h0, bus.pc}, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] tgt;
    int          sel;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: reset and free-run
    do_reset();
    idle(4);
    check_eq("t1_pc", {16'h0, bus.pc}, 32'h0000_0008);

    // 2: redirect from 0010 to 0040, two bubbles, then resume at 0040
    cyc(1'b0, 1'b0, 1'b1, 16'h0010);
    idle(SQ);
    check_eq("t2_pc_start", {16'h0, bus.pc}, 32'h0000_0010);
    cyc(1'b0, 1'b0, 1'b1, 16'h0040);
    check_eq("t2_squash", {31'h0, bus.squash}, 32'd1);
    idle(SQ + 2);
    check_eq("t2_pc_after", {16'h0, bus.pc}, 32'h0000_0044);

    // 3: newer redirect inside the squash window wins and restarts the bubbles
    cyc(1'b0, 1'b0, 1'b1, 16'h0040);
    cyc(1'b0, 1'b0, 1'b1, 16'h0080);
    idle(SQ + 1);

    // 4: redirect beats stall and halt; plain stall holds
    cyc(1'b1, 1'b1, 1'b1, 16'h0100);
    check_eq("t4_not_halted", {31'h0, bus.halted}, 32'd0);
    idle(SQ + 1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    idle(1);

    // 5: halt parks; redirect ignored; reset recovers
    cyc(1'b0, 1'b0, 1'b1, 16'h0020);
    idle(SQ);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("t5_pc_halt", {16'h0, bus.pc}, 32'h0000_0020);
    cyc(1'b0, 1'b0, 1'b1, 16'h0200);
    idle(2);
    do_reset();

    // reset during a squash window leaves no residual bubble
    cyc(1'b0, 1'b0, 1'b1, 16'h0300);
    idle(1);
    do_reset();
    idle(1);

    // 6: misaligned redirect, then PC wrap
    cyc(1'b0, 1'b0, 1'b1, 16'h0031);
    check_eq("t6_err", {31'h0, bus.err}, 32'd1);
    check_eq("t6_nosq", {31'h0, bus.squash}, 32'd0);
    idle(2);
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFC);
    idle(SQ + 2);
    check_eq("t6_wrap_pc", {16'h0, bus.pc}, 32'h0000_0000);
    check_eq("t6_wrap_err", {31'h0, bus.err}, 32'd1);
    idle(2);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 15);
        if (sel == 0)      tgt = 16'($urandom) | 16'h0001;
        else if (sel == 1) tgt = ($urandom_range(0, 1) == 0) ? 16'hFFFC : 16'hFFFE;
        else               tgt = 16'($urandom) & 16'hFFFE;
        cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 23) == 0),
            ($urandom_range(0, 5) == 0), tgt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
